life_gen_seq: RTL and testbench

LIFE_GEN_SEQ -- requirements
Module: life_gen_seq

---
 rtl/life_gen_seq_pkg.sv | 20 ++
 rtl/life_gen_seq_addr_gen.sv | 34 +++
 rtl/life_gen_seq.sv | 149 ++++++++++++++
 tb/tb_life_gen_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/life_gen_seq_pkg.sv
// Shared types and size helpers for the Life generation sequencer.
// Sizes derive from the grid dimensions.
package life_gen_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } life_state_e;

  function automatic int life_n(input int x, input int y);
    return (y + 2) * x + 1;
  endfunction

  function automatic int life_a(input int lx, input int ly);
    return lx + ly + 1;
  endfunction

endpackage

// File: rtl/life_gen_seq_addr_gen.sv
// Maps stream index k to cell-memory read and write row/col.
// Read rows walk Y-1,0..Y-1,0 then (1,0); writes trail by 2X+1.
module life_addr_gen
  import life_gen_seq_pkg::*;
#(
  parameter int X     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3,
  parameter int CW    = LOG2X + LOG2Y,
  parameter int KW    = LOG2X + LOG2Y + 2
) (
  input  logic [CW-1:0]    i_rk,
  input  logic [KW-1:0]    i_wk,
  output logic [LOG2Y-1:0] o_rd_row,
  output logic [LOG2X-1:0] o_rd_col,
  output logic [LOG2Y-1:0] o_wr_row,
  output logic [LOG2X-1:0] o_wr_col,
  output logic             o_wr_ok
);

  localparam logic [KW-1:0] WOFF = KW'(2 * X + 1);

  logic [CW-1:0] w_widx;

  // (e + Y - 1) mod Y only needs the low LOG2Y bits of e
  assign o_rd_row = i_rk[CW-1:LOG2X] - LOG2Y'(1);
  assign o_rd_col = i_rk[LOG2X-1:0];

  assign w_widx   = i_wk[CW-1:0] - CW'(2 * X + 1);
  assign o_wr_row = w_widx[CW-1:LOG2X];
  assign o_wr_col = w_widx[LOG2X-1:0];
  assign o_wr_ok  = (i_wk >= WOFF);

endmodule

// File: rtl/life_gen_seq.sv
// Life generation sequencer: streams one bank through the window
// pipes and writes next-state cells into the other bank.
module life_gen_seq
  import life_gen_seq_pkg::*;
#(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [7:0]             gens,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             gen_cnt,
  output logic                   bank,
  output logic                   rd_en,
  output logic [LOG2X+LOG2Y:0]   rd_addr,
  input  logic                   rd_data,
  output logic                   shift_en,
  output logic                   cell_in,
  input  logic                   next_cell,
  output logic                   wr_en,
  output logic [LOG2X+LOG2Y:0]   wr_addr,
  output logic                   wr_data
);

  localparam int A  = life_a(LOG2X, LOG2Y);
  localparam int N  = life_n(X, Y);
  localparam int CW = LOG2X + LOG2Y;
  localparam int KW = LOG2X + LOG2Y + 2;
  localparam logic [KW-1:0] KLAST = KW'(N - 1);

  life_state_e      r_state;
  logic [KW-1:0]    r_k;
  logic [KW-1:0]    r_k1;
  logic [7:0]       r_gen_cnt;
  logic [7:0]       r_gens;
  logic             r_bank;
  logic             r_drain;
  logic             r_sh;
  logic             r_wr;
  logic [LOG2Y-1:0] r_wr_row;
  logic [LOG2X-1:0] r_wr_col;

  logic             w_rd_en;
  logic [7:0]       w_gen_nx;
  logic [LOG2Y-1:0] w_rd_row;
  logic [LOG2X-1:0] w_rd_col;
  logic [LOG2Y-1:0] w_wr_row;
  logic [LOG2X-1:0] w_wr_col;
  logic             w_wr_ok;
  logic [A-1:0]     w_rd_addr;
  logic [A-1:0]     w_wr_addr;

  life_addr_gen #(
    .X     (X),
    .LOG2X (LOG2X),
    .LOG2Y (LOG2Y)
  ) u_addr (
    .i_rk     (r_k[CW-1:0]),
    .i_wk     (r_k1),
    .o_rd_row (w_rd_row),
    .o_rd_col (w_rd_col),
    .o_wr_row (w_wr_row),
    .o_wr_col (w_wr_col),
    .o_wr_ok  (w_wr_ok)
  );

  assign w_rd_en  = (r_state == S_STREAM);
  assign w_gen_nx = r_gen_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_gen_cnt <= '0;
      r_gens    <= '0;
      r_bank    <= 1'b0;
      r_drain   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_gens    <= gens;
            r_gen_cnt <= '0;
            r_k       <= '0;
            r_state   <= (gens != 8'd0) ? S_STREAM : S_DONE;
          end
        end
        S_STREAM: begin
          if (r_k == KLAST) begin
            r_k     <= '0;
            r_drain <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        S_DRAIN: begin
          if (r_drain) begin
            r_gen_cnt <= w_gen_nx;
            r_bank    <= ~r_bank;
            r_state   <= (w_gen_nx < r_gens) ? S_STREAM : S_DONE;
          end else begin
            r_drain <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobe delays: pipe shift one cycle after read, write one after that
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh     <= 1'b0;
      r_wr     <= 1'b0;
      r_k1     <= '0;
      r_wr_row <= '0;
      r_wr_col <= '0;
    end else begin
      r_sh     <= w_rd_en;
      r_k1     <= r_k;
      r_wr     <= r_sh & w_wr_ok;
      r_wr_row <= w_wr_row;
      r_wr_col <= w_wr_col;
    end
  end

  assign w_rd_addr = {r_bank, w_rd_row, w_rd_col};
  assign w_wr_addr = {~r_bank, r_wr_row, r_wr_col};

  assign busy     = (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign done     = (r_state == S_DONE);
  assign gen_cnt  = r_gen_cnt;
  assign bank     = r_bank;
  assign rd_en    = w_rd_en;
  assign rd_addr  = w_rd_addr;
  assign shift_en = r_sh;
  assign cell_in  = rd_data;
  assign wr_en    = r_wr;
  assign wr_addr  = w_wr_addr;
  assign wr_data  = next_cell;

endmodule

// File: tb/tb_life_gen_seq.sv
// Bench for life_gen_seq: cell memory, window unit and a Life
// reference model around the sequencer, random grids and gens.
module tb_life_gen_seq;

  localparam int X     = 8;
  localparam int Y     = 8;
  localparam int LOG2X = 3;
  localparam int LOG2Y = 3;
  localparam int XY    = X * Y;
  localparam int A     = LOG2X + LOG2Y + 1;
  localparam int N     = (Y + 2) * X + 1;
  localparam int P     = N + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   gens = '0;
  logic         busy, done, bank;
  logic [7:0]   gen_cnt;
  logic         rd_en, shift_en, cell_in, wr_en, wr_data;
  logic [A-1:0] rd_addr, wr_addr;
  logic         rd_data = 1'b0;
  logic         next_cell = 1'b0;

  logic [XY-1:0] mem [2];
  logic [XY-1:0] seed_grid = '0;
  logic          seed_bank = 1'b0;
  logic          seed_go = 1'b0;
  logic [N-1:0]  hist = '0;
  int            scnt = 0;

  int n_chk = 0;
  int n_fail = 0;
  int bk = 0;

  always #5 clk = ~clk;

  life_gen_seq #(
    .X(X), .Y(Y), .LOG2X(LOG2X), .LOG2Y(LOG2Y)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .gens      (gens),
    .busy      (busy),
    .done      (done),
    .gen_cnt   (gen_cnt),
    .bank      (bank),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .shift_en  (shift_en),
    .cell_in   (cell_in),
    .next_cell (next_cell),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Toroidal rows, dead columns
  function automatic logic [XY-1:0] life_step(input logic [XY-1:0] g);
    logic [XY-1:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < Y; r++)
      for (int c = 0; c < X; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0) && c + dc >= 0 && c + dc < X)
              cnt += int'(g[((r + dr + Y) % Y) * X + c + dc]);
        n[r * X + c] = (cnt == 3) || (g[r * X + c] && cnt == 2);
      end
    return n;
  endfunction

  // Window unit: stream position j holds extended-row cell j
  function automatic logic nb_next(input int j, input logic nc);
    int i, r, c, er, cnt, idx;
    logic v, ctr;
    i = j - 2 * X - 1;
    if (i < 0) return 1'b0;
    r = i / X;
    c = i % X;
    er = r + 1;
    cnt = 0;
    ctr = 1'b0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        if (c + dc >= 0 && c + dc < X) begin
          idx = (er + dr) * X + c + dc;
          v = (idx == j) ? nc : hist[idx];
          if (dr == 0 && dc == 0) ctr = v;
          else cnt += int'(v);
        end
      end
    return (cnt == 3) || (ctr && cnt == 2);
  endfunction

  always @(posedge clk) begin
    if (seed_go) mem[seed_bank] <= seed_grid;
    if (rd_en) rd_data <= mem[rd_addr[A-1]][rd_addr[A-2:0]];
    if (wr_en) mem[wr_addr[A-1]][wr_addr[A-2:0]] <= wr_data;
  end

  always @(posedge clk) begin
    if (shift_en && scnt < N) begin
      hist[scnt] <= cell_in;
      next_cell  <= nb_next(scnt, cell_in);
      scnt       <= scnt + 1;
    end else begin
      scnt <= 0;
    end
  end

  task automatic run(input int g, input int pulse,
                     input logic [XY-1:0] grid);
    logic [XY-1:0] exp_grid;
    logic er, esh, ewr, ebusy, edone;
    int gi, o, eb, lim, ndone;
    @(negedge clk);
    seed_grid = grid;
    seed_bank = bk[0];
    seed_go = 1'b1;
    @(negedge clk);
    seed_go = 1'b0;
    start = 1'b1;
    gens = 8'(g);
    @(negedge clk);
    start = 1'b0;
    gens = 8'($urandom);
    lim = g * P + 4;
    ndone = 0;
    for (int t = 0; t < lim; t++) begin
      gi = t / P;
      o = t % P;
      er = (gi < g) && (o < N);
      esh = (t >= 1) && ((t - 1) / P < g) && ((t - 1) % P < N);
      ewr = (gi < g) && (o >= 2 * X + 3) && (o <= N + 1);
      ebusy = (t < g * P);
      edone = (t == g * P);
      eb = bk ^ (gi & 1);
      chk($sformatf("strobes g=%0d t=%0d", g, t),
          {rd_en, shift_en, wr_en, busy, done},
          {er, esh, ewr, ebusy, edone});
      if (rd_en && er)
        chk($sformatf("rd_addr t=%0d", t), 64'(rd_addr),
            64'(eb * XY + ((o / X + Y - 1) % Y) * X + o % X));
      if (wr_en && ewr)
        chk($sformatf("wr_addr t=%0d", t), 64'(wr_addr),
            64'((1 - eb) * XY + o - 2 * X - 3));
      if (done) begin
        ndone++;
        chk("gen_cnt", 64'(gen_cnt), 64'(g));
        chk("bank", 64'(bank), 64'(bk ^ (g & 1)));
      end
      if (t == pulse) begin
        start = 1'b1;
        gens = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_count", 64'(ndone), 64'd1);
    if (g > 0) begin
      exp_grid = grid;
      for (int s = 0; s < g; s++) exp_grid = life_step(exp_grid);
      bk = bk ^ (g & 1);
      chk($sformatf("grid g=%0d", g), 64'(mem[bk]), 64'(exp_grid));
    end
  endtask

  task automatic mid_reset();
    int nq;
    @(negedge clk);
    start = 1'b1;
    gens = 8'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("busy_before_rst", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_strobes", 64'({rd_en, shift_en, wr_en, busy, done}), 64'd0);
    chk("rst_cnt_bank", 64'({gen_cnt, bank}), 64'd0);
    nq = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      nq += int'(rd_en) + int'(wr_en) + int'(shift_en);
    end
    chk("post_rst_quiet", 64'(nq), 64'd0);
    bk = 0;
  endtask

  initial begin
    logic [XY-1:0] gl;
    int g;
    gl = '0;
    gl[2 * X + 3] = 1'b1;
    gl[3 * X + 4] = 1'b1;
    gl[4 * X + 2] = 1'b1;
    gl[4 * X + 3] = 1'b1;
    gl[4 * X + 4] = 1'b1;
    mem[0] = '0;
    mem[1] = '0;
    repeat (3) @(negedge clk);
    chk("reset_strobes", 64'({rd_en, shift_en, wr_en, busy, done}), 64'd0);
    chk("reset_cnt_bank", 64'({gen_cnt, bank}), 64'd0);
    rst_n = 1'b1;
    run(1, -1, XY'({$urandom, $urandom}));
    mid_reset();
    run(3, 30, gl);
    run(0, -1, XY'({$urandom, $urandom}));
    for (int r = 0; r < 3; r++) begin
      g = int'($urandom_range(1, 2));
      run(g, int'($urandom_range(1, g * P - 1)), XY'({$urandom, $urandom}));
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
